// File: rtl/demux18_deser.sv
// demux18_deser: serial-to-parallel counterpart of the 8:1 multiplexer.
// Addressed mode steers each incoming bit to the output chosen by s.
// Framed mode collects eight bits in a shadow register, then updates all
// outputs at once and raises a one-cycle valid strobe.
module demux18_deser #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       d,
   input  logic       en,
   input  logic       mode,
   input  logic [2:0] s,
   input  logic       sync,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d_o,
   output logic       e,
   output logic       f,
   output logic       g,
   output logic       h,
   output logic       valid,
   output logic [2:0] idx,
   output logic       frame_err
);

   // Registered state
   logic [7:0] out_r;
   logic [7:0] shadow_r;
   logic [2:0] idx_r;
   logic       valid_r;
   logic       frame_err_r;
   logic       mode_q_r;

   // Next-state values
   logic [7:0] out_nxt_s;
   logic [7:0] shadow_nxt_s;
   logic [2:0] idx_nxt_s;
   logic       valid_nxt_s;
   logic       frame_err_nxt_s;

   // Helpers
   logic [2:0] pos_s;
   logic [2:0] first_pos_s;
   logic [7:0] shadow_wr_s;
   logic       mode_chg_s;

   // Bit position within the frame for the current index, honouring bit order.
   always_comb begin
      pos_s       = 3'd0;
      first_pos_s = 3'd0;
      shadow_wr_s = shadow_r;
      if (LSB_FIRST) begin
         pos_s       = idx_r;
         first_pos_s = 3'd0;
      end else begin
         pos_s       = 3'd7 - idx_r;
         first_pos_s = 3'd7;
      end
      shadow_wr_s[pos_s] = d;
   end

   assign mode_chg_s = (mode != mode_q_r);

   // Next-state logic for both modes; a mode change only clears framing state.
   always_comb begin
      out_nxt_s       = out_r;
      shadow_nxt_s    = shadow_r;
      idx_nxt_s       = idx_r;
      valid_nxt_s     = 1'b0;
      frame_err_nxt_s = 1'b0;
      if (mode_chg_s) begin
         idx_nxt_s    = 3'd0;
         shadow_nxt_s = 8'h00;
      end else if (!mode) begin
         idx_nxt_s = 3'd0;
         if (en) begin
            out_nxt_s[s] = d;
         end else begin
            out_nxt_s = out_r;
         end
      end else begin
         case ({en, sync})
            2'b10: begin
               shadow_nxt_s = shadow_wr_s;
               idx_nxt_s    = idx_r + 3'd1;
               if (idx_r == 3'd7) begin
                  out_nxt_s   = shadow_wr_s;
                  valid_nxt_s = 1'b1;
               end else begin
                  out_nxt_s   = out_r;
                  valid_nxt_s = 1'b0;
               end
            end
            2'b11: begin
               // Bit carried with sync starts a fresh frame.
               shadow_nxt_s              = 8'h00;
               shadow_nxt_s[first_pos_s] = d;
               idx_nxt_s                 = 3'd1;
               frame_err_nxt_s           = (idx_r != 3'd0);
            end
            2'b01: begin
               shadow_nxt_s    = 8'h00;
               idx_nxt_s       = 3'd0;
               frame_err_nxt_s = (idx_r != 3'd0);
            end
            default: begin
               shadow_nxt_s = shadow_r;
               idx_nxt_s    = idx_r;
            end
         endcase
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_r       <= 8'h00;
         shadow_r    <= 8'h00;
         idx_r       <= 3'd0;
         valid_r     <= 1'b0;
         frame_err_r <= 1'b0;
         mode_q_r    <= mode;
      end else begin
         out_r       <= out_nxt_s;
         shadow_r    <= shadow_nxt_s;
         idx_r       <= idx_nxt_s;
         valid_r     <= valid_nxt_s;
         frame_err_r <= frame_err_nxt_s;
         mode_q_r    <= mode;
      end
   end

   assign a         = out_r[0];
   assign b         = out_r[1];
   assign c         = out_r[2];
   assign d_o       = out_r[3];
   assign e         = out_r[4];
   assign f         = out_r[5];
   assign g         = out_r[6];
   assign h         = out_r[7];
   assign valid     = valid_r;
   assign idx       = idx_r;
   assign frame_err = frame_err_r;

endmodule
